mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter MAX_WORD, default 9, meaning the highest valid word index of the data memory (words 0..MAX_WORD).
REQ-002 The block SHALL have port clock, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 The block SHALL have ports p0_req / p1_req, input, 1, access request from port 0 (CPU data) / port 1 (loader).
REQ-005 The block SHALL have ports p0_we / p1_we, input, 1, 1 = write and 0 = read, valid while req is high.
REQ-006 The block SHALL have ports p0_addr / p1_addr, input, 32, byte address, valid while req is high.
REQ-007 The block SHALL have ports p0_wdata / p1_wdata, input, 32, write data, valid while req is high.
REQ-008 The block SHALL have ports p0_ack / p1_ack, output, 1, one-cycle completion pulse.
REQ-009 The block SHALL have ports p0_err / p1_err, output, 1, error flag, valid only with ack.
REQ-010 The block SHALL have ports p0_rdata / p1_rdata, output, 32, read data, valid only with ack.
REQ-011 The block SHALL have ports mwr, moe, output, 1 each, memory write enable and output enable.
REQ-012 The block SHALL have ports ma, mwd, output, 32 each, memory byte address and write data.
REQ-013 The block SHALL have port mrd, input, 32, combinational memory read data.

Function
REQ-014 The FSM SHALL have three states: IDLE, GRANT and DONE; encoding is free.
REQ-015 IDLE: if any req is high, the block SHALL select a winner, latch its we, addr and wdata, and go to GRANT; otherwise it SHALL stay in IDLE.
REQ-016 Arbitration SHALL be round-robin: a lone requester wins; when both requesters are high, the port not granted last wins.
REQ-017 last_grant SHALL update only when a port is selected.
REQ-018 GRANT: for a valid request, ma and mwd SHALL be driven from the latched values, and either mwr=1 (write) or moe=1 (read) SHALL be asserted for exactly this one cycle.
REQ-019 For a valid read in GRANT, the block SHALL capture mrd at the end of the cycle.
REQ-020 GRANT SHALL always go to DONE.
REQ-021 A request SHALL be valid only when addr[1:0]=0 and addr[31:2] <= MAX_WORD.
REQ-022 For an invalid request in GRANT, mwr, moe, ma and mwd SHALL all stay 0, and the captured data SHALL be 0.
REQ-023 DONE: the winner's ack SHALL be 1 for one cycle.
REQ-024 In DONE, the winner's err SHALL be 1 if the request was invalid, else 0.
REQ-025 In DONE, the winner's rdata SHALL be the captured data (0 for writes and for errors).
REQ-026 DONE SHALL always go to IDLE.
REQ-027 Latency: a req first high in IDLE cycle N SHALL give memory access in cycle N+1 and ack in cycle N+2; maximum throughput is one access per 3 cycles.
REQ-028 A requester SHALL hold req and its fields stable until it sees ack, and drop req on the cycle after ack unless it issues a new request.
REQ-029 If req drops before ack, the latched transaction SHALL still complete and be acked.
REQ-030 Outside DONE, every ack and err SHALL be 0; the non-winner's ack, err and rdata SHALL be 0 at all times.
REQ-031 Outside GRANT, mwr, moe, ma and mwd SHALL be 0.
REQ-032 All outputs SHALL be registered or decoded only from state; mrd SHALL reach the outputs only through the capture register.

Reset
REQ-033 While reset is high, state SHALL be IDLE and last_grant SHALL be 1, so port 0 wins the first contention.
REQ-034 While reset is high, all outputs and latched registers SHALL be 0.
REQ-035 Asserting reset in GRANT SHALL drop mwr and moe immediately, with no write committed at the next edge and no ack issued.
REQ-036 After reset deasserts, pending requests SHALL be re-arbitrated from IDLE.

Verification
REQ-037 Scenario single write/read: p0 write addr 0x8, wdata 0xDEADBEEF -> cycle N+1 mwr=1, ma=0x8, mwd=0xDEADBEEF; cycle N+2 p0_ack=1, err=0. Then p0 read 0x8 -> cycle N+1 moe=1; N+2 p0_rdata=0xDEADBEEF.
REQ-038 Scenario contention: p0 and p1 both requested in the same cycle after reset -> p0 acked first; p1 granted on the next IDLE; a repeated tie then goes to p0 after p1.
REQ-039 Scenario errors: p1 read 0x6 (misaligned) and p1 write 0x28 (word 10 > 9) -> each acked at N+2 with p1_err=1, rdata=0, and mwr=moe=0 throughout.
REQ-040 Scenario reset mid-access: reset raised asynchronously in GRANT of a write to 0x4 -> mwr falls the same cycle, the memory word is unchanged, and no ack is issued.
REQ-041 Scenario streaming: p0 holds back-to-back reads of 0x0 and 0x4 while p1 is idle -> acks spaced exactly 3 cycles apart, with correct data each time.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-ported word memory.
// Each access runs IDLE -> GRANT -> DONE: one memory cycle, then a one-cycle ack.
module mem_arbiter #(
    parameter int MAX_WORD = 9
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        p0_req,
    input  logic        p0_we,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    input  logic        p1_req,
    input  logic        p1_we,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    output logic        p0_ack,
    output logic        p0_err,
    output logic [31:0] p0_rdata,
    output logic        p1_ack,
    output logic        p1_err,
    output logic [31:0] p1_rdata,
    output logic        mwr,
    output logic        moe,
    output logic [31:0] ma,
    output logic [31:0] mwd,
    input  logic [31:0] mrd
);

    localparam logic [31:0] MAX_WORD_L = 32'(MAX_WORD);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;

    logic        last_grant;
    logic        sel;
    logic        lat_we;
    logic        lat_valid;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [31:0] cap_data;

    logic        any_req;
    logic        pick_p1;
    logic        pick_we;
    logic [31:0] pick_addr;
    logic [31:0] pick_wdata;
    logic        pick_valid;
    logic        access;
    logic        done;

    // Round-robin: on a tie the port that did not win last time goes next.
    always_comb begin
        any_req    = p0_req | p1_req;
        pick_p1    = p1_req & (~p0_req | ~last_grant);
        pick_we    = pick_p1 ? p1_we    : p0_we;
        pick_addr  = pick_p1 ? p1_addr  : p0_addr;
        pick_wdata = pick_p1 ? p1_wdata : p0_wdata;
        pick_valid = (pick_addr[1:0] == 2'b00) &&
                     ({2'b00, pick_addr[31:2]} <= MAX_WORD_L);
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (any_req) state_next = GRANT;
            GRANT:   state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            sel        <= 1'b0;
            lat_we     <= 1'b0;
            lat_valid  <= 1'b0;
            lat_addr   <= 32'h0;
            lat_wdata  <= 32'h0;
            cap_data   <= 32'h0;
        end else begin
            state <= state_next;
            if (state == IDLE && any_req) begin
                sel        <= pick_p1;
                last_grant <= pick_p1;
                lat_we     <= pick_we;
                lat_valid  <= pick_valid;
                lat_addr   <= pick_addr;
                lat_wdata  <= pick_wdata;
                cap_data   <= 32'h0;
            end
            if (state == GRANT) begin
                cap_data <= (lat_valid && !lat_we) ? mrd : 32'h0;
            end
        end
    end

    // Memory strobes are decoded from state, so an async reset in GRANT drops them at once.
    assign access = (state == GRANT) && lat_valid;
    assign mwr    = access & lat_we;
    assign moe    = access & ~lat_we;
    assign ma     = access ? lat_addr  : 32'h0;
    assign mwd    = access ? lat_wdata : 32'h0;

    assign done     = (state == DONE);
    assign p0_ack   = done & ~sel;
    assign p1_ack   = done & sel;
    assign p0_err   = p0_ack & ~lat_valid;
    assign p1_err   = p1_ack & ~lat_valid;
    assign p0_rdata = p0_ack ? cap_data : 32'h0;
    assign p1_rdata = p1_ack ? cap_data : 32'h0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small word-memory model on the memory port.
// Inputs change and outputs are sampled 1 time unit after each rising clock edge.
module tb_mem_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        p0_req, p0_we, p1_req, p1_we;
    logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
    logic        p0_ack, p0_err, p1_ack, p1_err;
    logic [31:0] p0_rdata, p1_rdata;
    logic        mwr, moe;
    logic [31:0] ma, mwd, mrd;

    logic [31:0] mem [0:15];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    always @(posedge clock) begin
        if (mwr) mem[ma[5:2]] <= mwd;
    end

    assign mrd = moe ? mem[ma[5:2]] : 32'h0;

    mem_arbiter #(.MAX_WORD(9)) dut (
        .clock(clock), .reset(reset),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p0_ack(p0_ack), .p0_err(p0_err), .p0_rdata(p0_rdata),
        .p1_ack(p1_ack), .p1_err(p1_err), .p1_rdata(p1_rdata),
        .mwr(mwr), .moe(moe), .ma(ma), .mwd(mwd), .mrd(mrd)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input int port, input logic req, input logic we,
                                 input logic [31:0] addr, input logic [31:0] wdata);
        if (port == 0) begin
            p0_req = req; p0_we = we; p0_addr = addr; p0_wdata = wdata;
        end else begin
            p1_req = req; p1_we = we; p1_addr = addr; p1_wdata = wdata;
        end
    endtask

    // One isolated access starting from IDLE: request, GRANT cycle, DONE cycle, back to IDLE.
    task automatic runAccess(input int port, input logic we, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic valid,
                             input logic [31:0] exp_rdata, input string tag);
        logic [1:0] exp_ack;
        exp_ack = (port == 0) ? 2'b01 : 2'b10;
        applyStimulus(port, 1'b1, we, addr, wdata);
        tick();
        checkOutput({tag, ".mwr"}, 32'(mwr), 32'(valid & we));
        checkOutput({tag, ".moe"}, 32'(moe), 32'(valid & ~we));
        checkOutput({tag, ".ma"}, ma, valid ? addr : 32'h0);
        checkOutput({tag, ".mwd"}, mwd, valid ? wdata : 32'h0);
        checkOutput({tag, ".ack_early"}, 32'({p1_ack, p0_ack}), 32'h0);
        tick();
        checkOutput({tag, ".ack"}, 32'({p1_ack, p0_ack}), 32'(exp_ack));
        checkOutput({tag, ".err"}, 32'({p1_err, p0_err}), valid ? 32'h0 : 32'(exp_ack));
        checkOutput({tag, ".rdata"}, (port == 0) ? p0_rdata : p1_rdata, exp_rdata);
        checkOutput({tag, ".other_rdata"}, (port == 0) ? p1_rdata : p0_rdata, 32'h0);
        checkOutput({tag, ".strobes_done"}, 32'({mwr, moe}), 32'h0);
        applyStimulus(port, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        checkOutput({tag, ".ack_idle"}, 32'({p1_ack, p0_ack}), 32'h0);
    endtask

    // Bounded wait for an ack on a port; returns the cycle count at which it was seen.
    task automatic waitAck(input int port, input string tag, output int at_cyc);
        logic seen;
        seen = 1'b0;
        at_cyc = 0;
        for (int i = 0; i < 8 && !seen; i++) begin
            tick();
            if ((port == 0 && p0_ack) || (port == 1 && p1_ack)) begin
                seen = 1'b1;
                at_cyc = cyc;
            end
        end
        checkOutput({tag, ".ack_seen"}, 32'(seen), 32'h1);
    endtask

    task automatic doReset();
        applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0);
        applyStimulus(1, 1'b0, 1'b0, 32'h0, 32'h0);
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    initial begin
        int t1, t2;
        reset = 1'b1;
        applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0);
        applyStimulus(1, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        tick();
        checkOutput("rst.ack", 32'({p1_ack, p0_ack}), 32'h0);
        checkOutput("rst.err", 32'({p1_err, p0_err}), 32'h0);
        checkOutput("rst.strobes", 32'({mwr, moe}), 32'h0);
        checkOutput("rst.ma", ma, 32'h0);
        checkOutput("rst.mwd", mwd, 32'h0);
        checkOutput("rst.p0_rdata", p0_rdata, 32'h0);
        checkOutput("rst.p1_rdata", p1_rdata, 32'h0);
        reset = 1'b0;
        tick();

        $display("[TB] single write/read");
        runAccess(0, 1'b1, 32'h8, 32'hDEADBEEF, 1'b1, 32'h0, "wr8");
        runAccess(0, 1'b0, 32'h8, 32'h0, 1'b1, 32'hDEADBEEF, "rd8");

        $display("[TB] error and boundary accesses");
        runAccess(1, 1'b0, 32'h6, 32'h0, 1'b0, 32'h0, "err_misalign");
        runAccess(1, 1'b1, 32'h28, 32'h55555555, 1'b0, 32'h0, "err_range");
        runAccess(1, 1'b1, 32'h24, 32'h99999999, 1'b1, 32'h0, "wr_word9");
        runAccess(1, 1'b0, 32'h24, 32'h0, 1'b1, 32'h99999999, "rd_word9");

        $display("[TB] contention");
        doReset();
        applyStimulus(0, 1'b1, 1'b1, 32'h0, 32'h11111111);
        applyStimulus(1, 1'b1, 1'b1, 32'h4, 32'h22222222);
        tick();
        checkOutput("cont.g1_ma", ma, 32'h0);
        tick();
        checkOutput("cont.ack1", 32'({p1_ack, p0_ack}), 32'h1);
        tick();
        checkOutput("cont.idle_ack", 32'({p1_ack, p0_ack}), 32'h0);
        tick();
        checkOutput("cont.g2_ma", ma, 32'h4);
        checkOutput("cont.g2_mwd", mwd, 32'h22222222);
        tick();
        checkOutput("cont.ack2", 32'({p1_ack, p0_ack}), 32'h2);
        tick();
        tick();
        checkOutput("cont.g3_ma", ma, 32'h0);
        tick();
        checkOutput("cont.ack3", 32'({p1_ack, p0_ack}), 32'h1);
        applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0);
        applyStimulus(1, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        tick();
        checkOutput("cont.quiet", 32'({p1_ack, p0_ack, mwr, moe}), 32'h0);

        $display("[TB] reset during GRANT");
        applyStimulus(0, 1'b1, 1'b1, 32'h4, 32'hCAFEF00D);
        tick();
        checkOutput("rstg.mwr_before", 32'(mwr), 32'h1);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("rstg.mwr_now", 32'(mwr), 32'h0);
        checkOutput("rstg.ma_now", ma, 32'h0);
        applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        checkOutput("rstg.mem1", mem[1], 32'h22222222);
        checkOutput("rstg.ack", 32'({p1_ack, p0_ack}), 32'h0);
        reset = 1'b0;
        tick();
        checkOutput("rstg.ack_after", 32'({p1_ack, p0_ack}), 32'h0);

        $display("[TB] streaming reads");
        applyStimulus(0, 1'b1, 1'b0, 32'h0, 32'h0);
        waitAck(0, "strm1", t1);
        checkOutput("strm1.rdata", p0_rdata, 32'h11111111);
        applyStimulus(0, 1'b1, 1'b0, 32'h4, 32'h0);
        waitAck(0, "strm2", t2);
        checkOutput("strm2.rdata", p0_rdata, 32'h22222222);
        checkOutput("strm.spacing", 32'(t2 - t1), 32'h3);
        applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
